ifid_skid_stage: RTL and testbench
==================================

# ifid_skid_stage

Parametrised IF/ID pipeline boundary register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble insertion. It sits between the fetch stage and the decode stage. It replaces the plain stall-hold register with a fully registered interface: no combinational path exists from `out_ready` to `in_ready`. On flush, and whenever the stage is empty, it presents a NOP bubble downstream. It also counts downstream back-pressure cycles for performance analysis.

## Interface
Parameters:
- `INSTR_W`, default 32: instruction width.
- `PC_W`, default 64: PC width.
- `NOP_INSTR`, default 32'h00000013: value driven on `out_instr` when `out_valid` is 0. Width is `INSTR_W`.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `flush`, in, 1: synchronous squash of all held entries (branch/jump redirect).
- `in_valid`, in, 1: fetch presents an instruction.
- `in_ready`, out, 1: stage can accept. Registered output.
- `in_instr`, in, `INSTR_W`: fetched instruction.
- `in_pc`, in, `PC_W`: PC of the fetched instruction.
- `out_valid`, out, 1: decode-side entry valid.
- `out_ready`, in, 1: decode accepts. Hazard-unit stall drives this low.
- `out_instr`, out, `INSTR_W`: instruction to decode. Equals `NOP_INSTR` when `out_valid` is 0.
- `out_pc`, out, `PC_W`: PC to decode. Equals 0 when `out_valid` is 0.
- `occupancy`, out, 2: number of entries held, 0 to 2.
- `stall_cnt`, out, `CNT_W`: saturating count of back-pressure cycles.

## Operation
Definitions:
- accept = `in_valid & in_ready`.
- deliver = `out_valid & out_ready`.

Storage:
- A main register drives the outputs.
- A skid register holds at most one extra entry.

States:
- EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
- The state encodes occupancy directly.

Transitions when `flush` is 0:
- EMPTY, accept: main <= input; go to ONE.
- ONE, accept with no deliver: skid <= input; go to FULL.
- ONE, accept with deliver: main <= input; stay in ONE.
- ONE, deliver with no accept: go to EMPTY.
- ONE, neither: hold.
- FULL, deliver: main <= skid; go to ONE. Accept cannot occur in FULL because `in_ready` is 0.
- FULL, no deliver: hold all contents.

Derived outputs:
- `in_ready` is registered. Its next value is 1 unless the next state is FULL.
- `out_valid` = (state != EMPTY).
- `out_instr` / `out_pc` = main contents when valid, otherwise `NOP_INSTR` / 0.

Flush:
- Highest priority after reset.
- Next state is EMPTY, both registers are invalidated, and `in_ready` becomes 1.
- A handshake that completes in the flush cycle, on either side, is consumed and discarded.

Ordering:
- Strict FIFO order. An entry is never duplicated or dropped except by flush.

`stall_cnt`:
- Increments in each cycle where `out_valid & ~out_ready`.
- Saturates at all-ones and does not wrap.
- Unaffected by flush. Cleared only by reset.

## Timing
- Reset values:
  - state EMPTY, `occupancy` 0
  - `in_ready` 1
  - `out_valid` 0
  - `out_instr` `NOP_INSTR`
  - `out_pc` 0
  - `stall_cnt` 0
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency: an input accepted at edge N appears on the outputs after edge N (one cycle) when the stage was EMPTY, or when it was ONE with a deliver in the same cycle.
- Throughput: one entry per cycle sustained while `out_ready` is 1.
- Back-pressure: after `out_ready` falls, the stage absorbs at most one further accept. `in_ready` drops on the edge that enters FULL.
- `in_ready` rises one edge after the FULL-to-ONE deliver.
- Flush at edge N: `out_valid` is 0 and `out_instr` is `NOP_INSTR` after edge N. A new input can be accepted at edge N+1.
- `flush` and `reset` together: reset dominates.

## Test plan
- Reset, then stream PCs 0x0, 0x4, 0x8 with `out_ready`=1 -> each appears on `out_pc` one cycle after acceptance; `occupancy` stays 1; `stall_cnt`=0.
- With `occupancy`=1, drop `out_ready` for 3 cycles while `in_valid`=1 with PCs 0x10, 0x14 -> 0x14 is captured in skid; `in_ready` is 0 after that edge; `occupancy`=2; `stall_cnt`=3; on release, 0x10 then 0x14 are delivered in order.
- In FULL, assert `flush` with `out_ready`=0 -> next cycle `out_valid`=0, `out_instr`=32'h00000013, `out_pc`=0, `in_ready`=1, `occupancy`=0.
- Assert `flush` and accept PC 0x20 in the same cycle -> 0x20 is never delivered; the next accept, PC 0x24, delivers normally.
- Hold `out_valid`=1 and `out_ready`=0 for 2^`CNT_W`+5 cycles -> `stall_cnt` holds at all-ones.
- Assert `reset` asynchronously mid-stream between edges -> outputs take their reset values immediately; after release, the first accept delivers correctly.

Source files
------------

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline boundary with a registered valid/ready handshake and a two-entry skid buffer.
// Presents a NOP bubble whenever empty or flushed, and counts downstream back-pressure cycles.
module ifid_skid_stage #(
    parameter int unsigned          INSTR_W   = 32,
    parameter int unsigned          PC_W      = 64,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    // The encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               valid_int;
    logic               accept;
    logic               deliver;

    assign valid_int = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign deliver   = valid_int & out_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a path
        // that skips an assignment infers a latch.
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // Handshakes completing this cycle are consumed and dropped.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end else if (accept) begin
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                        state_d      = ST_FULL;
                    end else if (deliver) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a deliver can move us.
                    if (deliver) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        state_d      = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Registered ready: looks only at our own next state, never at out_ready directly.
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_int && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: payload registers are not reset; validity lives entirely in state_q and
    // the outputs are masked while empty, so stale payload is never observable.
    always_ff @(posedge clk) begin
        main_instr_q <= main_instr_d;
        main_pc_q    <= main_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_int;
    assign out_instr = valid_int ? main_instr_q : NOP_INSTR;
    assign out_pc    = valid_int ? main_pc_q : '0;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage: a queue-based reference model is compared every
// cycle, with directed scenarios pinned by literal expectations and a randomized stream.
module tb_ifid_skid_stage;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;
    localparam int unsigned CNT_W   = 6;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   stall_cnt;

    ifid_skid_stage #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries plus a ready bit and a saturating counter.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t           m_q[$];
    bit               m_rdy;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_rdy = 1'b1;
            m_cnt = '0;
        end else begin
            bit acc, del;
            acc = in_valid && m_rdy;
            del = (m_q.size() != 0) && out_ready;
            if ((m_q.size() != 0) && !out_ready && (m_cnt != CNT_MAX)) m_cnt = m_cnt + 1'b1;
            if (flush) begin
                m_q.delete();
            end else begin
                if (del) void'(m_q.pop_front());
                if (acc) m_q.push_back('{instr: in_instr, pc: in_pc});
            end
            m_rdy = (m_q.size() < 2);
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit v;
            v = (m_q.size() != 0);
            check("out_valid", 64'(out_valid), 64'(v));
            check("out_instr", 64'(out_instr), v ? 64'(m_q[0].instr) : 64'(NOP));
            check("out_pc",    64'(out_pc),    v ? 64'(m_q[0].pc) : 64'd0);
            check("in_ready",  64'(in_ready),  64'(m_rdy));
            check("occupancy", 64'(occupancy), 64'(m_q.size()));
            check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
    end

    // Drives one cycle of inputs just after a rising edge, then waits for the next edge.
    task automatic cycle(input bit iv, input logic [PC_W-1:0] pc, input bit ordy, input bit fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = 32'hA000_0000 | 32'(pc);
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_occ"},   64'(occupancy), 64'd0);
        check({tag, "_rdy"},   64'(in_ready),  64'd1);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_instr"}, 64'(out_instr), 64'h13);
        check({tag, "_pc"},    64'(out_pc),    64'd0);
        check({tag, "_cnt"},   64'(stall_cnt), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        chk_en = 1'b1;

        // Streaming with out_ready high: one-cycle latency, occupancy stays 1.
        cycle(1, 64'h0, 1, 0);
        check("s0_pc", 64'(out_pc), 64'h0);
        check("s0_occ", 64'(occupancy), 64'd1);
        cycle(1, 64'h4, 1, 0);
        check("s4_pc", 64'(out_pc), 64'h4);
        cycle(1, 64'h8, 1, 0);
        check("s8_pc", 64'(out_pc), 64'h8);
        check("s8_occ", 64'(occupancy), 64'd1);
        check("s8_cnt", 64'(stall_cnt), 64'd0);

        // Back-pressure: 0x10 in main, 0x14 goes to skid, then hold.
        cycle(1, 64'h10, 1, 0);
        check("bp_main", 64'(out_pc), 64'h10);
        cycle(1, 64'h14, 0, 0);
        check("bp_rdy0", 64'(in_ready), 64'd0);
        check("bp_occ2", 64'(occupancy), 64'd2);
        cycle(1, 64'h18, 0, 0);
        cycle(1, 64'h18, 0, 0);
        check("bp_cnt3", 64'(stall_cnt), 64'd3);
        check("bp_hold", 64'(out_pc), 64'h10);
        cycle(0, 64'h0, 1, 0);
        check("bp_rel1", 64'(out_pc), 64'h14);
        check("bp_rdy1", 64'(in_ready), 64'd1);
        cycle(0, 64'h0, 1, 0);
        check("bp_empty", 64'(occupancy), 64'd0);

        // Fill to FULL, then flush while stalled.
        cycle(1, 64'h30, 0, 0);
        cycle(1, 64'h34, 0, 0);
        check("fl_full", 64'(occupancy), 64'd2);
        cycle(0, 64'h0, 0, 1);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_instr", 64'(out_instr), 64'h13);
        check("fl_pc",    64'(out_pc),    64'd0);
        check("fl_rdy",   64'(in_ready),  64'd1);
        check("fl_occ",   64'(occupancy), 64'd0);

        // Accept coinciding with flush is discarded; the next one flows.
        cycle(1, 64'h20, 1, 1);
        check("fa_valid", 64'(out_valid), 64'd0);
        cycle(1, 64'h24, 1, 0);
        check("fa_pc", 64'(out_pc), 64'h24);
        cycle(0, 64'h0, 1, 0);

        // Counter saturation: hold a valid entry with out_ready low past wrap.
        cycle(1, 64'h40, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) cycle(0, 64'h0, 0, 0);
        check("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        cycle(0, 64'h0, 1, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset between edges while holding data.
        cycle(1, 64'h50, 0, 0);
        cycle(1, 64'h54, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1, 64'h60, 1, 0);
        check("post_rst_pc", 64'(out_pc), 64'h60);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        cycle(0, 64'h0, 1, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
